dnn_word_fetcher: RTL and testbench



---
 rtl/dnn_mem_pkg.sv | 18 +
 rtl/dnn_fetch_fifo.sv | 68 ++++++
 rtl/dnn_word_fetcher.sv | 162 ++++++++++++++++
 tb/tb_dnn_word_fetcher.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_mem_pkg.sv
// Shared definitions for the DNN memory engines.
//   fetch_state_t  : word fetcher control states
//   WORD_BYTES     : byte stride between consecutive 32-bit words
//   AVALON_ADDR_W  : Avalon-MM byte address width
//   WORD_W         : data word width
package dnn_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } fetch_state_t;

    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned AVALON_ADDR_W = 32;
    localparam int unsigned WORD_W        = 32;

endpackage

// File: rtl/dnn_fetch_fifo.sv
// First-word-fall-through FIFO holding fetched words plus their last flag.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data this cycle
//   push_data  : {last, word}
//   pop        : consume the head (ignored while empty)
//   pop_data   : head entry, '0 while empty
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
module dnn_fetch_fifo
    import dnn_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = WORD_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // a push into a full FIFO is only taken when the head leaves in the same cycle
        do_push  = push && ((count_q != OCC_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == OCC_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/dnn_word_fetcher.sv
// Read-side memory engine: takes one (address, word count) command, issues
// pipelined Avalon-MM reads at consecutive word addresses and streams the
// returned words to the core through a FWFT FIFO with a last flag.
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only while idle)
//   cmd_addr, cmd_count   : byte address of first word (bits [1:0] ignored), word count
//   data_valid/data_ready : output stream handshake
//   data_word, data_last  : FIFO head word and its end-of-command flag
//   busy                  : command in progress
//   master_*              : Avalon-MM read master
module dnn_word_fetcher
    import dnn_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [AVALON_ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]         cmd_count,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic [WORD_W-1:0]        data_word,
    output logic                     data_last,
    output logic                     busy,
    input  logic                     master_waitrequest,
    output logic [AVALON_ADDR_W-1:0] master_address,
    output logic                     master_read,
    input  logic [WORD_W-1:0]        master_readdata,
    input  logic                     master_readdatavalid
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    fetch_state_t             state_q, state_d;
    logic [AVALON_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]         issue_left_q, issue_left_d;
    logic [CNT_W-1:0]         deliv_left_q, deliv_left_d;
    logic [OCC_W-1:0]         outstanding_q, outstanding_d;
    logic                     read_q, read_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     busy_q, busy_d;

    logic                     cmd_take, req_accept, resp_push, head_pop, push_last;
    logic [OCC_W-1:0]         fifo_count, fifo_count_next;
    logic [OCC_W:0]           occ_next;
    logic                     fifo_full, fifo_empty;
    logic [WORD_W:0]          head;

    always_comb begin
        cmd_take   = cmd_ready_q && cmd_valid;
        req_accept = read_q && !master_waitrequest;
        // responses with nothing outstanding are leftovers from before a reset
        resp_push  = master_readdatavalid && (outstanding_q != '0);
        head_pop   = !fifo_empty && data_ready;
        push_last  = (deliv_left_q == CNT_W'(1));

        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        deliv_left_d = deliv_left_q;

        case (state_q)
            IDLE: begin
                if (cmd_take) begin
                    addr_d       = cmd_addr & ~AVALON_ADDR_W'(WORD_BYTES - 1);
                    issue_left_d = cmd_count;
                    deliv_left_d = cmd_count;
                    if (cmd_count != '0) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (req_accept) begin
                    addr_d       = addr_q + AVALON_ADDR_W'(WORD_BYTES);
                    issue_left_d = issue_left_q - CNT_W'(1);
                    if (issue_left_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((outstanding_q == '0) && fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (resp_push) begin
            deliv_left_d = deliv_left_q - CNT_W'(1);
        end

        outstanding_d   = outstanding_q + OCC_W'(req_accept) - OCC_W'(resp_push);
        fifo_count_next = fifo_count + OCC_W'(resp_push) - OCC_W'(head_pop);
        occ_next        = {1'b0, outstanding_d} + {1'b0, fifo_count_next};

        // credit is judged on next-cycle occupancy so the accept happening now
        // is already counted; a stalled request is held regardless of credit
        if (read_q && master_waitrequest) begin
            read_d = 1'b1;
        end else begin
            read_d = (state_d == ISSUE) && (issue_left_d != '0) &&
                     (occ_next < (OCC_W + 1)'(DEPTH));
        end

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            issue_left_q  <= '0;
            deliv_left_q  <= '0;
            outstanding_q <= '0;
            read_q        <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            issue_left_q  <= issue_left_d;
            deliv_left_q  <= deliv_left_d;
            outstanding_q <= outstanding_d;
            read_q        <= read_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
        end
    end

    dnn_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_push),
        .push_data ({push_last, master_readdata}),
        .pop       (head_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assert property (@(posedge clk) disable iff (rst) !(resp_push && fifo_full && !head_pop))
        else $error("word fetcher FIFO overflow");

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign master_read    = read_q;
    assign master_address = addr_q;
    assign data_valid     = !fifo_empty;
    assign data_word      = head[WORD_W-1:0];
    assign data_last      = head[WORD_W];

endmodule

// File: tb/tb_dnn_word_fetcher.sv
module tb_dnn_word_fetcher;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_addr = '0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             data_valid;
    logic             data_ready = 1'b0;
    logic [31:0]      data_word;
    logic             data_last;
    logic             busy;
    logic             master_waitrequest;
    logic [31:0]      master_address;
    logic             master_read;
    logic [31:0]      master_readdata = '0;
    logic             master_readdatavalid = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    dnn_word_fetcher #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_addr             (cmd_addr),
        .cmd_count            (cmd_count),
        .data_valid           (data_valid),
        .data_ready           (data_ready),
        .data_word            (data_word),
        .data_last            (data_last),
        .busy                 (busy),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid)
    );

    // SDRAM model: three waitrequest cycles per request, data two cycles after accept
    logic [1:0]  wait_cnt = '0;
    logic        st_v = 1'b0;
    logic [31:0] st_d = '0;
    logic [31:0] acc_q [$];

    assign master_waitrequest = (wait_cnt != 2'd3);

    always @(posedge clk) begin
        if (master_read && !master_waitrequest) begin
            st_v <= 1'b1;
            st_d <= {master_address[15:0], master_address[15:0]};
        end else begin
            st_v <= 1'b0;
        end
        master_readdatavalid <= st_v;
        master_readdata      <= st_d;
        if (!master_read || wait_cnt == 2'd3) wait_cnt <= '0;
        else                                  wait_cnt <= wait_cnt + 2'd1;
        if (!rst && master_read && !master_waitrequest) acc_q.push_back(master_address);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // a stalled request must keep read and address steady
    logic        hold_prev = 1'b0;
    logic [31:0] hold_addr = '0;
    always @(negedge clk) begin
        if (!rst && hold_prev) begin
            chk("hold_read", {31'b0, master_read}, 32'd1);
            chk("hold_addr", master_address, hold_addr);
        end
        hold_prev = !rst && master_read && master_waitrequest;
        hold_addr = master_address;
    end

    function automatic logic [31:0] exp_word(input logic [31:0] base, input int unsigned i);
        logic [31:0] a;
        a = base + 32'(4 * i);
        return {a[15:0], a[15:0]};
    endfunction

    typedef struct {
        string       name;
        logic [31:0] addr;
        int unsigned count;
        int unsigned mode;     // 1: ready=1, 2: long back-pressure, 3: random ready
        logic [31:0] first_w;
        logic [31:0] last_w;
    } vec_t;

    vec_t vecs [8];

    task automatic issue(input logic [31:0] a, input int unsigned c);
        int unsigned t = 0;
        while (!cmd_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
        acc_q.delete();
        cmd_addr  = a;
        cmd_count = CNT_W'(c);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v);
        logic [31:0] base, first_w, last_w;
        int unsigned got = 0;
        int unsigned cyc = 0;
        logic saw_read = 1'b0, saw_valid = 1'b0, saw_notready = 1'b0;
        base    = v.addr & 32'hFFFF_FFFC;
        first_w = '0;
        last_w  = '0;
        issue(v.addr, v.count);
        if (v.count == 0) begin
            repeat (20) begin
                if (master_read) saw_read = 1'b1;
                if (data_valid)  saw_valid = 1'b1;
                if (!cmd_ready)  saw_notready = 1'b1;
                @(posedge clk); #1;
            end
            chk({v.name, "_read"}, {31'b0, saw_read}, 32'd0);
            chk({v.name, "_valid"}, {31'b0, saw_valid}, 32'd0);
            chk({v.name, "_cmd_ready_drop"}, {31'b0, saw_notready}, 32'd0);
            chk({v.name, "_busy"}, {31'b0, busy}, 32'd0);
            return;
        end
        chk({v.name, "_busy_start"}, {31'b0, busy}, 32'd1);
        while (got < v.count && cyc < 3000) begin
            case (v.mode)
                2: begin
                    if (cyc == 120) begin
                        chk({v.name, "_accepts_at_credit_limit"}, acc_q.size(), DEPTH);
                        chk({v.name, "_read_low_when_full"}, {31'b0, master_read}, 32'd0);
                    end
                    data_ready = (cyc >= 120);
                end
                3:       data_ready = 1'($urandom_range(0, 1));
                default: data_ready = 1'b1;
            endcase
            if (data_valid && data_ready) begin
                chk($sformatf("%s_word%0d", v.name, got), data_word, exp_word(base, got));
                chk($sformatf("%s_last%0d", v.name, got), {31'b0, data_last},
                    {31'b0, (got == v.count - 1)});
                if (got == 0) first_w = data_word;
                last_w = data_word;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        data_ready = 1'b0;
        chk({v.name, "_word_count"}, got, v.count);
        chk({v.name, "_first"}, first_w, v.first_w);
        chk({v.name, "_lastword"}, last_w, v.last_w);
        cyc = 0;
        while (busy && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk({v.name, "_busy_end"}, {31'b0, busy}, 32'd0);
        chk({v.name, "_cmd_ready_end"}, {31'b0, cmd_ready}, 32'd1);
        chk({v.name, "_valid_end"}, {31'b0, data_valid}, 32'd0);
        chk({v.name, "_accept_count"}, acc_q.size(), v.count);
        for (int k = 0; k < acc_q.size() && k < int'(v.count); k++) begin
            chk($sformatf("%s_addr%0d", v.name, k), acc_q[k], base + 32'(4 * k));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int unsigned t;
        logic saw_valid;

        vecs[0] = '{"basic",     32'h0000_0100,  3, 1, 32'h0100_0100, 32'h0108_0108};
        vecs[1] = '{"zero",      32'h0000_0100,  0, 1, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{"unaligned", 32'h0000_0103,  2, 1, 32'h0100_0100, 32'h0104_0104};
        vecs[3] = '{"wrap16",    32'h0000_FFFC,  2, 1, 32'hFFFC_FFFC, 32'h0000_0000};
        vecs[4] = '{"wrap32",    32'hFFFF_FFF8,  3, 1, 32'hFFF8_FFF8, 32'h0000_0000};
        vecs[5] = '{"wait10",    32'h0000_0100, 10, 1, 32'h0100_0100, 32'h0124_0124};
        vecs[6] = '{"bp20",      32'h0000_0100, 20, 2, 32'h0100_0100, 32'h014C_014C};
        vecs[7] = '{"rand50",    32'h0000_0300, 50, 3, 32'h0300_0300, 32'h03C4_03C4};

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_read", {31'b0, master_read}, 32'd0);
        chk("rst_address", master_address, 32'd0);
        chk("rst_valid", {31'b0, data_valid}, 32'd0);
        chk("rst_word", data_word, 32'd0);
        chk("rst_last", {31'b0, data_last}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i]);
        end

        // reset after two of six reads are accepted
        issue(32'h0000_0400, 6);
        data_ready = 1'b1;
        t = 0;
        while (acc_q.size() < 2 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("midrst_two_accepts", acc_q.size(), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_read", {31'b0, master_read}, 32'd0);
        chk("midrst_valid", {31'b0, data_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        saw_valid = 1'b0;
        repeat (6) begin
            if (data_valid) saw_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("midrst_stale_push", {31'b0, saw_valid}, 32'd0);
        data_ready = 1'b0;
        v = '{"after_rst", 32'h0000_0200, 2, 1, 32'h0200_0200, 32'h0204_0204};
        run_cmd(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
